updown_count_ctrl: RTL and testbench

Command-driven sequencer for the 3-bit asynchronous up/down ripple counter. It accepts step commands over a valid/ready handshake, applies the count direction safely, and issues one clock pulse per step with enough settle time for the ripple chain. It tracks the expected count, checks it against the counter's observed outputs, and flags any mismatch. It sits between the control logic and the counter's `clk`, `m` and `ta`/`tb`/`tc` inputs.

---
 rtl/updown_count_ctrl_pkg.sv | 18 +
 rtl/updown_count_ctrl_if.sv | 13 +
 rtl/updown_count_ctrl_settle_timer.sv | 33 +++
 rtl/updown_count_ctrl.sv | 132 +++++++++++++
 tb/tb_updown_count_ctrl.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/updown_count_ctrl_pkg.sv
// Shared types and constants for the up/down ripple-counter sequencer.
package updown_ctrl_pkg;

   localparam int STEP_W = 4;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      MODE,
      PULSE,
      GAP,
      CHECK,
      DONE
   } state_e;

endpackage

// File: rtl/updown_count_ctrl_if.sv
// Step-command handshake between the control logic and the counter sequencer.
interface updown_count_ctrl_if;
   import updown_ctrl_pkg::*;

   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_dir;
   logic [STEP_W-1:0] cmd_steps;

   modport master (output cmd_valid, output cmd_dir, output cmd_steps, input cmd_ready);
   modport slave  (input cmd_valid, input cmd_dir, input cmd_steps, output cmd_ready);

endinterface

// File: rtl/updown_count_ctrl_settle_timer.sv
// Loadable down-counter; expire is high while the count sits at zero.
module settle_timer #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         expire
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire = (cnt_q == '0);

endmodule

// File: rtl/updown_count_ctrl.sv
// Sequencer for the ripple up/down counter: mode settle, tick, ripple settle, compare.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// MODE  | m applied with T inputs off; last cycle resyncs exp_q to the counter
// PULSE | one tick with T inputs on; exp_q steps
// GAP   | tick low, T inputs on while the ripple completes
// CHECK | T inputs off, compare counter against prediction
// DONE  | one-cycle completion pulse
module updown_count_ctrl
   import updown_ctrl_pkg::*;
#(
   parameter int WIDTH  = 3,
   parameter int SETTLE = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   updown_count_ctrl_if.slave cmd,
   output logic             cnt_mode,
   output logic             cnt_tick,
   output logic [WIDTH-1:0] cnt_en,
   input  logic [WIDTH-1:0] cnt_q,
   output logic [WIDTH-1:0] exp_q,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam int TW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [TW-1:0]    TMR_LOAD = TW'(SETTLE - 1);
   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

   state_e            state_q, state_d;
   logic [STEP_W-1:0] steps_q, steps_d;
   logic [WIDTH-1:0]  exp_q_q, exp_q_d;
   logic              err_q, err_d;
   logic              mode_q, mode_d;
   logic              tick_q, tick_d;
   logic [WIDTH-1:0]  en_q, en_d;
   logic              tmr_load, tmr_expire;

   settle_timer #(.W(TW)) u_settle (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (TMR_LOAD),
      .expire   (tmr_expire)
   );

   always_comb begin
      state_d = state_q;
      steps_d = steps_q;
      exp_q_d = exp_q_q;
      err_d   = err_q;
      mode_d  = mode_q;
      unique case (state_q)
         IDLE: begin
            if (cmd.cmd_valid) begin
               steps_d = cmd.cmd_steps;
               err_d   = 1'b0;
               if (cmd.cmd_steps == '0) begin
                  state_d = DONE;
               end else begin
                  mode_d  = cmd.cmd_dir;
                  state_d = MODE;
               end
            end
         end
         MODE: begin
            if (tmr_expire) begin
               exp_q_d = cnt_q;
               state_d = PULSE;
            end
         end
         PULSE: begin
            exp_q_d = (mode_q == DIR_DOWN) ? exp_q_q - ONE : exp_q_q + ONE;
            state_d = GAP;
         end
         GAP: begin
            if (tmr_expire) state_d = CHECK;
         end
         CHECK: begin
            // A mismatch abandons the remaining steps; the next command resyncs.
            if (cnt_q != exp_q_q) begin
               err_d   = 1'b1;
               state_d = DONE;
            end else begin
               steps_d = steps_q - STEP_W'(1);
               state_d = (steps_q == STEP_W'(1)) ? DONE : PULSE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      tmr_load = ((state_d == MODE) && (state_q != MODE)) ||
                 ((state_d == GAP)  && (state_q != GAP));
      // Counter-facing strobes are registered from the next state so they never glitch.
      tick_d = (state_d == PULSE);
      en_d   = ((state_d == PULSE) || (state_d == GAP)) ? '1 : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         steps_q <= '0;
         exp_q_q <= '1;
         err_q   <= 1'b0;
         mode_q  <= DIR_UP;
         tick_q  <= 1'b0;
         en_q    <= '0;
      end else begin
         state_q <= state_d;
         steps_q <= steps_d;
         exp_q_q <= exp_q_d;
         err_q   <= err_d;
         mode_q  <= mode_d;
         tick_q  <= tick_d;
         en_q    <= en_d;
      end
   end

   assign cmd.cmd_ready = (state_q == IDLE);
   assign busy          = (state_q != IDLE);
   assign done          = (state_q == DONE);
   assign err           = err_q;
   assign exp_q         = exp_q_q;
   assign cnt_mode      = mode_q;
   assign cnt_tick      = tick_q;
   assign cnt_en        = en_q;

endmodule

// File: tb/tb_updown_count_ctrl.sv
// Bench for updown_count_ctrl driving a behavioural 3-bit ripple up/down counter.
module tb_updown_count_ctrl;
   import updown_ctrl_pkg::*;

   localparam int WIDTH  = 3;
   localparam int SETTLE = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   updown_count_ctrl_if cmd_if();

   logic             cnt_mode, cnt_tick, busy, done, err;
   logic [WIDTH-1:0] cnt_en, cnt_q, exp_q;

   updown_count_ctrl #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cmd      (cmd_if),
      .cnt_mode (cnt_mode),
      .cnt_tick (cnt_tick),
      .cnt_en   (cnt_en),
      .cnt_q    (cnt_q),
      .exp_q    (exp_q),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   // Ripple counter: negative-edge T flops, later stages clocked by q (up) or ~q (down).
   logic qa = 1'b1, qb = 1'b1, qc = 1'b1;
   logic [2:0] stuck_mask = 3'b000, stuck_val = 3'b000;
   wire clk_b = cnt_mode ? ~qa : qa;
   wire clk_c = cnt_mode ? ~qb : qb;
   always @(negedge cnt_tick) if (cnt_en[0] === 1'b1) qa <= ~qa;
   always @(negedge clk_b)    if (cnt_en[1] === 1'b1) qb <= ~qb;
   always @(negedge clk_c)    if (cnt_en[2] === 1'b1) qc <= ~qc;
   assign cnt_q = ({qc, qb, qa} & ~stuck_mask) | (stuck_val & stuck_mask);

   int checks = 0, failures = 0;
   int ref_count = 7;
   int ref_mode  = 0;

   int r_lat, r_ticks, r_err_c1, r_err_done, r_exp_done, r_cnt_done, r_ready_after;
   bit r_en_mode_bad, r_gap_bad, r_mode_chg, r_timeout;
   int trace[$];

   typedef struct {
      logic dir;
      int   steps;
      int   lat;
      int   ticks;
      int   final_q;
      int   mode;
   } vec_t;
   vec_t vecs[6];

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   function automatic int model_lat(input int n);
      return (n == 0) ? 1 : SETTLE + n * (SETTLE + 2) + 1;
   endfunction

   function automatic int model_step(input int start, input logic d, input int k);
      return (((start + (d ? -k : k)) % 8) + 8) % 8;
   endfunction

   task automatic run_cmd(input logic d, input int n, input int stuck_tick);
      int  low;
      int  m0;
      bit  prev_tick;
      trace.delete();
      r_lat = 0; r_ticks = 0; low = 0; m0 = 0; prev_tick = 0;
      r_en_mode_bad = 0; r_gap_bad = 0; r_mode_chg = 0; r_err_c1 = 0;
      @(negedge clk);
      chk("ready_before_cmd", int'(cmd_if.cmd_ready), 1);
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_dir   = d;
      cmd_if.cmd_steps = 4'(n);
      @(posedge clk);
      #1 cmd_if.cmd_valid = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         r_lat++;
         if (prev_tick) trace.push_back(int'(exp_q));
         prev_tick = cnt_tick;
         if (r_lat == 1) begin
            m0 = int'(cnt_mode);
            r_err_c1 = int'(err);
         end else if (int'(cnt_mode) != m0) begin
            r_mode_chg = 1;
         end
         if (cnt_tick) begin
            if (r_ticks > 0 && low < SETTLE) r_gap_bad = 1;
            r_ticks++;
            low = 0;
            if (r_ticks == stuck_tick) begin
               stuck_val  = {qc, qb, qa};
               stuck_mask = 3'b001;
            end
         end else begin
            low++;
            if (r_ticks == 0 && busy && !done && cnt_en != '0) r_en_mode_bad = 1;
         end
         if (done) break;
      end
      r_timeout  = !done;
      r_err_done = int'(err);
      r_exp_done = int'(exp_q);
      r_cnt_done = int'(cnt_q);
      @(negedge clk);
      r_ready_after = int'(cmd_if.cmd_ready);
   endtask

   task automatic apply(input string name, input logic d, input int n, input int e_lat,
                        input int e_ticks, input int e_final, input int e_mode);
      run_cmd(d, n, 0);
      chk({name, "_timeout"}, int'(r_timeout), 0);
      chk({name, "_latency"}, r_lat, e_lat);
      chk({name, "_ticks"}, r_ticks, e_ticks);
      chk({name, "_exp_q"}, r_exp_done, e_final);
      chk({name, "_cnt_q"}, r_cnt_done, e_final);
      chk({name, "_err"}, r_err_done, 0);
      chk({name, "_mode"}, int'(cnt_mode), e_mode);
      chk({name, "_mode_stable"}, int'(r_mode_chg), 0);
      chk({name, "_en_in_mode"}, int'(r_en_mode_bad), 0);
      chk({name, "_tick_gap"}, int'(r_gap_bad), 0);
      chk({name, "_ready_after_done"}, r_ready_after, 1);
      chk({name, "_trace_len"}, trace.size(), n);
      foreach (trace[k]) chk({name, "_trace"}, trace[k], model_step(ref_count, d, k + 1));
      ref_count = e_final;
      ref_mode  = e_mode;
   endtask

   initial begin
      int start, n, d;
      vecs[0] = '{1'b0, 1, 7,  1, 0, 0};
      vecs[1] = '{1'b0, 1, 7,  1, 1, 0};
      vecs[2] = '{1'b1, 3, 15, 3, 6, 1};
      vecs[3] = '{1'b0, 0, 1,  0, 6, 1};
      vecs[4] = '{1'b0, 2, 11, 2, 0, 0};
      vecs[5] = '{1'b1, 2, 11, 2, 6, 1};

      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_dir   = 1'b0;
      cmd_if.cmd_steps = 4'd0;
      #2 rst_n = 1'b0;
      #20;
      chk("rst_ready", int'(cmd_if.cmd_ready), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_tick", int'(cnt_tick), 0);
      chk("rst_en", int'(cnt_en), 0);
      chk("rst_mode", int'(cnt_mode), 0);
      chk("rst_exp_q", int'(exp_q), 7);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++)
         apply($sformatf("vec%0d", i), vecs[i].dir, vecs[i].steps, vecs[i].lat,
               vecs[i].ticks, vecs[i].final_q, vecs[i].mode);

      for (int i = 0; i < 10; i++) begin
         d = int'($urandom_range(0, 1));
         n = int'($urandom_range(0, 5));
         apply($sformatf("rnd%0d", i), d[0], n, model_lat(n), n,
               model_step(ref_count, d[0], n), (n == 0) ? ref_mode : d);
      end

      // Stuck bit during the second step of a five-step command.
      start = ref_count;
      run_cmd(1'b0, 5, 2);
      chk("fault_timeout", int'(r_timeout), 0);
      chk("fault_ticks", r_ticks, 2);
      chk("fault_err", r_err_done, 1);
      chk("fault_latency", r_lat, model_lat(2));
      repeat (3) @(negedge clk);
      chk("fault_err_sticky", int'(err), 1);
      stuck_mask = 3'b000;
      ref_count  = model_step(start, 1'b0, 2);
      ref_mode   = 0;
      apply("post_fault", 1'b0, 1, model_lat(1), 1, model_step(ref_count, 1'b0, 1), 0);
      chk("post_fault_err_cleared", r_err_c1, 0);

      // Reset during GAP after the first tick of a three-step up command.
      @(negedge clk);
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_dir   = 1'b0;
      cmd_if.cmd_steps = 4'd3;
      @(posedge clk);
      #1 cmd_if.cmd_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (cnt_tick) break;
      end
      chk("midgap_tick_seen", int'(cnt_tick), 1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midgap_rst_busy", int'(busy), 0);
      chk("midgap_rst_ready", int'(cmd_if.cmd_ready), 1);
      chk("midgap_rst_en", int'(cnt_en), 0);
      chk("midgap_rst_tick", int'(cnt_tick), 0);
      chk("midgap_rst_exp_q", int'(exp_q), 7);
      chk("midgap_rst_err_done", int'({err, done}), 0);
      chk("midgap_rst_mode", int'(cnt_mode), 0);
      @(negedge clk);
      rst_n = 1'b1;
      ref_count = model_step(ref_count, 1'b0, 1);
      ref_mode  = 0;
      apply("post_rst", 1'b0, 1, model_lat(1), 1, model_step(ref_count, 1'b0, 1), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
